// File: rtl/double_buffer_reader.sv
// Reads each freshly filled double-buffer half and re-emits it as a framed valid/ready stream.
// A small skid FIFO absorbs downstream backpressure while RAM reads are still in flight.
module double_buffer_reader #(
  parameter int DATA_WIDTH      = 16,
  parameter int SAMPLES_PER_BUF = 256,
  parameter int ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF),
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  buf_ready_pulse_i,
  input  logic                  buf_ready_id_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_data_valid_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  out_buf_id_o,
  output logic                  busy_o,
  output logic                  overrun_pulse_o,
  output logic [15:0]           overrun_count_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);
  localparam logic [CW:0]           DEPTH_W   = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]         PTR_MAX   = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  rd_en_reg, rd_en_next;
  logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
  logic [1:0]            inflight_reg, inflight_next;
  logic [CW-1:0]         fifo_count_reg, fifo_count_next;
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic                  frame_id_reg, frame_id_next;
  logic                  pending_reg, pending_next;
  logic                  pending_id_reg, pending_id_next;
  logic                  overrun_pulse_reg;
  logic [15:0]           overrun_count_reg;

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic                  last_mem [FIFO_DEPTH];

  logic        busy, overrun, push, pop, push_last, room, drain_done, start, start_id;
  logic [CW:0] occupancy;

  assign busy      = (state_reg != IDLE);
  assign overrun   = buf_ready_pulse_i && busy;
  assign push      = rd_data_valid_i && (inflight_reg != 2'd0);
  assign pop       = (fifo_count_reg != '0) && out_ready_i;
  // Reads return in order, so the push that empties inflight during DRAIN is the final address.
  assign push_last = (state_reg == DRAIN) && (inflight_reg == 2'd1);
  assign occupancy = {1'b0, fifo_count_reg} + (CW+1)'(inflight_reg);
  assign room      = occupancy < DEPTH_W;
  // Exit on the cycle the last beat leaves so busy drops right after it.
  assign drain_done = (inflight_reg == 2'd0) &&
                      ((fifo_count_reg == '0) || ((fifo_count_reg == CW'(1)) && pop));
  assign start_id  = buf_ready_pulse_i ? buf_ready_id_i : pending_id_reg;

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    rd_en_next      = 1'b0;
    rd_addr_next    = rd_addr_reg;
    frame_id_next   = frame_id_reg;
    pending_next    = pending_reg;
    pending_id_next = pending_id_reg;
    start           = 1'b0;

    if (overrun) begin
      pending_next    = 1'b1;
      pending_id_next = buf_ready_id_i;
    end

    case (state_reg)
      IDLE: start = buf_ready_pulse_i || pending_reg;
      READ: begin
        if (room) begin
          rd_en_next   = 1'b1;
          rd_addr_next = addr_reg;
          if (addr_reg == LAST_ADDR) state_next = DRAIN;
          else                       addr_next  = addr_reg + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_done) begin
          if (pending_reg || buf_ready_pulse_i) start      = 1'b1;
          else                                  state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame entry issues address 0 immediately; the FIFO and pipeline are empty here.
    if (start) begin
      state_next    = READ;
      frame_id_next = start_id;
      pending_next  = 1'b0;
      rd_en_next    = 1'b1;
      rd_addr_next  = '0;
      addr_next     = ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    inflight_next = inflight_reg;
    case ({rd_en_next, push})
      2'b10:   inflight_next = inflight_reg + 2'd1;
      2'b01:   inflight_next = inflight_reg - 2'd1;
      default: inflight_next = inflight_reg;
    endcase
    fifo_count_next = fifo_count_reg;
    case ({push, pop})
      2'b10:   fifo_count_next = fifo_count_reg + CW'(1);
      2'b01:   fifo_count_next = fifo_count_reg - CW'(1);
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      rd_en_reg         <= 1'b0;
      rd_addr_reg       <= '0;
      inflight_reg      <= 2'd0;
      fifo_count_reg    <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      frame_id_reg      <= 1'b0;
      pending_reg       <= 1'b0;
      pending_id_reg    <= 1'b0;
      overrun_pulse_reg <= 1'b0;
      overrun_count_reg <= 16'd0;
    end else begin
      state_reg         <= state_next;
      addr_reg          <= addr_next;
      rd_en_reg         <= rd_en_next;
      rd_addr_reg       <= rd_addr_next;
      inflight_reg      <= inflight_next;
      fifo_count_reg    <= fifo_count_next;
      frame_id_reg      <= frame_id_next;
      pending_reg       <= pending_next;
      pending_id_reg    <= pending_id_next;
      overrun_pulse_reg <= overrun;
      if (overrun && (overrun_count_reg != 16'hFFFF))
        overrun_count_reg <= overrun_count_reg + 16'd1;
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_MAX) ? '0 : wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_MAX) ? '0 : rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= rd_data_i;
      last_mem[wr_ptr_reg] <= push_last;
    end
  end

  assign rd_en_o         = rd_en_reg;
  assign rd_addr_o       = rd_addr_reg;
  assign out_valid_o     = (fifo_count_reg != '0);
  assign out_data_o      = out_valid_o ? data_mem[rd_ptr_reg] : '0;
  assign out_last_o      = out_valid_o && last_mem[rd_ptr_reg];
  assign out_buf_id_o    = frame_id_reg;
  assign busy_o          = busy;
  assign overrun_pulse_o = overrun_pulse_reg;
  assign overrun_count_o = overrun_count_reg;

endmodule

// File: tb/tb_double_buffer_reader.sv
// Directed bench for double_buffer_reader: table of whole-frame vectors plus overrun,
// mid-frame reset and stray read-valid sequences against a 1-cycle-latency RAM model.
module tb_double_buffer_reader;
  localparam int DW = 16, SPB = 256, AW = 8, FD = 4;

  logic clk = 1'b0, rst_n = 1'b0, pulse = 1'b0, pulse_id = 1'b0, out_ready = 1'b1;
  logic rd_en, rd_data_valid, out_valid, out_last, out_buf_id, busy, ovr_pulse;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, out_data;
  logic [15:0]   ovr_count;
  logic          ram_valid, spur = 1'b0;
  logic [15:0]   ram_base = 16'h1000;

  always #5 clk = ~clk;

  double_buffer_reader #(.DATA_WIDTH(DW), .SAMPLES_PER_BUF(SPB), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .buf_ready_pulse_i(pulse), .buf_ready_id_i(pulse_id),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data), .rd_data_valid_i(rd_data_valid),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .out_buf_id_o(out_buf_id), .busy_o(busy), .overrun_pulse_o(ovr_pulse), .overrun_count_o(ovr_count)
  );

  // RAM model: word at address a holds ram_base + a, one cycle of read latency.
  assign rd_data_valid = ram_valid | spur;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_valid <= 1'b0;
      rd_data   <= '0;
    end else begin
      ram_valid <= rd_en;
      rd_data   <= ram_base + 16'(rd_addr);
    end
  end

  int n_vec = 0, n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Occupancy scoreboard: FIFO contents and outstanding reads may never exceed FD.
  int occ = 0, outst = 0, inv_viol = 0, stab_viol = 0, mon_o;
  logic mon_push, hold_prev = 1'b0, last_prev;
  logic [DW-1:0] data_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0; outst = 0; hold_prev = 1'b0;
    end else begin
      mon_o = outst + int'(rd_en);
      if (occ + mon_o > FD) inv_viol++;
      if (out_valid !== (occ != 0)) inv_viol++;
      if (hold_prev && (!out_valid || out_data !== data_prev || out_last !== last_prev)) stab_viol++;
      mon_push = rd_data_valid && (mon_o > 0);
      outst = mon_o - int'(mon_push);
      occ = occ + int'(mon_push) - int'(out_valid && out_ready);
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
      last_prev = out_last;
    end
  end

  logic [15:0] bq_data[$];
  logic        bq_last[$];
  logic        bq_id[$];
  int          bq_cyc[$];
  int          pulse_at[3];
  logic        pulse_idv[3];
  int          n_pulses = 0;
  int          ovr_seen, busy_low, stall_rd_en, snap_occ;
  logic [16:0] snap_out;
  logic [8:0]  c1_rd;
  logic        busy_after;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pulse = 1'b0; out_ready = 1'b1;
    end
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready low for 20 cycles at beat 10
  task automatic run_seq(input logic id0, input int mode, input int total, input int max_cyc);
    int cyc = 0, stall_cnt = 0, stall_idx = 0;
    bit stalled = 0, snap_done = 0;
    bit fired[3] = '{0, 0, 0};
    bq_data.delete(); bq_last.delete(); bq_id.delete(); bq_cyc.delete();
    ovr_seen = 0; busy_low = 0; stall_rd_en = 0; snap_occ = -1; snap_out = '0; c1_rd = '0;
    @(posedge clk); #1;
    pulse = 1'b1; pulse_id = id0;
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cyc < max_cyc) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        bq_data.push_back(out_data); bq_last.push_back(out_last);
        bq_id.push_back(out_buf_id); bq_cyc.push_back(cyc);
      end
      if (ovr_pulse) ovr_seen++;
      if (cyc >= 1 && !busy) busy_low++;
      if (cyc == 1) c1_rd = {rd_en, rd_addr};
      if (mode == 2 && !out_ready) begin
        stall_idx++;
        if (stall_idx > 10 && rd_en) stall_rd_en++;
      end
      if (bq_data.size() >= total) break;
      @(posedge clk); #1;
      cyc++;
      pulse = 1'b0;
      for (int j = 0; j < n_pulses; j++) begin
        if (!fired[j] && !pulse && bq_data.size() >= pulse_at[j]) begin
          fired[j] = 1; pulse = 1'b1; pulse_id = pulse_idv[j];
        end
      end
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (!stalled && bq_data.size() == 10) begin stalled = 1; stall_cnt = 20; end
        if (stall_cnt > 0) begin
          out_ready = 1'b0; stall_cnt--;
        end else begin
          out_ready = 1'b1;
          if (stalled && !snap_done) begin
            snap_done = 1; snap_occ = occ; snap_out = {out_valid, out_data};
          end
        end
      end else out_ready = 1'b1;
    end
    check("beats_received", bq_data.size(), total);
    @(posedge clk); #1;
    pulse = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic check_frame(input string tag, input int first, input logic [15:0] base, input logic exp_id);
    for (int i = 0; i < SPB; i++) begin
      if (first + i < bq_data.size())
        check($sformatf("%s_beat%0d", tag, i),
              {14'd0, bq_id[first+i], bq_last[first+i], bq_data[first+i]},
              {14'd0, exp_id, (i == SPB - 1), base + 16'(i)});
      else begin
        n_vec++; n_miss++;
        $display("FAIL %s_beat%0d: got no beat, required 0x%0h", tag, i, base + 16'(i));
      end
    end
  endtask

  typedef struct {
    logic        id;
    int          mode;
    logic [15:0] base;
    logic        exp_id;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          first_cyc;   // -1: not checked
    int          last_cyc;
  } vec_t;

  vec_t vecs[4];
  int   quiet;

  initial begin
    vecs[0] = '{1'b1, 0, 16'h1000, 1'b1, 16'h1000, 16'h10FF, 3, 258};
    vecs[1] = '{1'b0, 1, 16'h1000, 1'b0, 16'h1000, 16'h10FF, -1, -1};
    vecs[2] = '{1'b1, 2, 16'h1000, 1'b1, 16'h1000, 16'h10FF, 3, 278};
    vecs[3] = '{1'b0, 0, 16'h3000, 1'b0, 16'h3000, 16'h30FF, 3, 258};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {rd_en, rd_addr, out_valid, out_data, out_last, out_buf_id, busy, ovr_pulse},
          32'd0);
    check("reset_ovr_count", ovr_count, 0);
    rst_n = 1'b1;
    idle(3);

    for (int v = 0; v < 4; v++) begin
      n_pulses = 0;
      ram_base = vecs[v].base;
      run_seq(vecs[v].id, vecs[v].mode, SPB, 3000);
      check_frame($sformatf("vec%0d", v), 0, vecs[v].exp_first, vecs[v].exp_id);
      if (bq_data.size() >= SPB) begin
        check($sformatf("vec%0d_last_data", v), bq_data[SPB-1], vecs[v].exp_last);
        if (vecs[v].first_cyc >= 0) check($sformatf("vec%0d_first_cycle", v), bq_cyc[0], vecs[v].first_cyc);
        if (vecs[v].last_cyc >= 0) check($sformatf("vec%0d_last_cycle", v), bq_cyc[SPB-1], vecs[v].last_cyc);
      end
      check($sformatf("vec%0d_cycle1_rd", v), c1_rd, {1'b1, 8'd0});
      check($sformatf("vec%0d_busy_gap", v), busy_low, 0);
      check($sformatf("vec%0d_busy_after", v), busy_after, 0);
      check($sformatf("vec%0d_occ_bound", v), inv_viol, 0);
      check($sformatf("vec%0d_stable", v), stab_viol, 0);
      if (vecs[v].mode == 2) begin
        check("stall_buffered", snap_occ, FD);
        check("stall_head", snap_out, {1'b1, 16'h100A});
        check("stall_rd_en", stall_rd_en, 0);
      end
      idle(5);
    end

    // single overrun mid-frame: queued frame follows with no idle gap
    ram_base = 16'h1000;
    n_pulses = 1; pulse_at[0] = 100; pulse_idv[0] = 1'b0;
    run_seq(1'b1, 0, 2 * SPB, 3000);
    check("ovA_pulse_cycles", ovr_seen, 1);
    check("ovA_count", ovr_count, 1);
    check("ovA_busy_gap", busy_low, 0);
    check_frame("ovA_f1", 0, 16'h1000, 1'b1);
    check_frame("ovA_f2", SPB, 16'h1000, 1'b0);
    if (bq_cyc.size() >= 2 * SPB) begin
      check("ovA_f2_first_cycle", bq_cyc[SPB], 261);
      check("ovA_f2_last_cycle", bq_cyc[2*SPB-1], 516);
    end
    check("ovA_busy_after", busy_after, 0);
    idle(5);

    // reset at beat 50 aborts the frame with all outputs cleared at once
    n_pulses = 0;
    run_seq(1'b1, 0, 50, 1000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {rd_en, rd_addr, out_valid, out_data, out_last, out_buf_id, busy, ovr_pulse},
          32'd0);
    check("midrst_ovr_count", ovr_count, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || busy || rd_en || out_last) quiet++;
    end
    check("midrst_quiet", quiet, 0);

    // three overruns queue exactly one frame carrying the last ID
    n_pulses = 3;
    pulse_at[0] = 50; pulse_idv[0] = 1'b1;
    pulse_at[1] = 60; pulse_idv[1] = 1'b1;
    pulse_at[2] = 70; pulse_idv[2] = 1'b0;
    run_seq(1'b1, 0, 2 * SPB, 3000);
    check("ovB_pulse_cycles", ovr_seen, 3);
    check("ovB_count", ovr_count, 3);
    check_frame("ovB_f1", 0, 16'h1000, 1'b1);
    check_frame("ovB_f2", SPB, 16'h1000, 1'b0);
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || busy || rd_en) quiet++;
    end
    check("ovB_no_third_frame", quiet, 0);

    // read-valid with nothing in flight must be ignored
    n_pulses = 0;
    @(posedge clk); #1; spur = 1'b1;
    @(posedge clk); #1; spur = 1'b0;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    check("stray_valid_ignored", quiet, 0);
    check("final_occ_bound", inv_viol, 0);
    check("final_stable", stab_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/double_buffer_reader.md
# double_buffer_reader

Consumer-side companion to `double_buffer_ram`. On each `buf_ready_pulse` it reads the just-filled (inactive) buffer from address 0 to SAMPLES_PER_BUF-1 through the RAM's 1-cycle-latency read port. It re-emits the samples as a valid/ready stream with frame framing (`last`, buffer ID). It sits between the double buffer and downstream processing (FFT / feature extraction) and absorbs downstream backpressure with a small skid FIFO.

## Interface
- DATA_WIDTH, 16, sample width; must match the RAM.
- SAMPLES_PER_BUF, 256, samples per frame; any value ≥ 2, not necessarily a power of two.
- ADDR_WIDTH, $clog2(SAMPLES_PER_BUF), RAM read address width.
- FIFO_DEPTH, 4, skid FIFO depth; fixed ≥ 4 to cover 2 reads in flight.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- buf_ready_pulse_i  in  1  one-cycle "buffer filled" strobe from the RAM.
- buf_ready_id_i  in  1  ID of the filled buffer; valid with the pulse.
- rd_en_o  out  1  RAM read enable; registered.
- rd_addr_o  out  ADDR_WIDTH  RAM read address; registered.
- rd_data_i  in  DATA_WIDTH  RAM read data.
- rd_data_valid_i  in  1  read data valid; asserted 1 cycle after rd_en_o.
- out_valid_o  out  1  stream valid.
- out_ready_i  in  1  stream ready.
- out_data_o  out  DATA_WIDTH  sample.
- out_last_o  out  1  final sample of the frame.
- out_buf_id_o  out  1  buffer ID of the frame being streamed.
- busy_o  out  1  frame in progress (READ or DRAIN).
- overrun_pulse_o  out  1  one-cycle strobe: a pulse arrived while busy.
- overrun_count_o  out  16  saturating count of overruns.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE → READ when `buf_ready_pulse_i` is high, or when `pending` is set. On entry: latch the buffer ID, set the address counter to 0, clear `pending`.
- READ: issue one read per cycle while `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` counts reads issued but not yet written into the FIFO, range 0..2.
  - The address increments on each issue.
  - When the read at SAMPLES_PER_BUF-1 is issued, go to DRAIN.
  - The address never wraps inside a frame.
- DRAIN: no new reads. Leave when inflight = 0 and the FIFO is empty.
  - Go to READ if `pending` is set (same entry actions as above).
  - Otherwise go to IDLE.
- FIFO write: each `rd_data_valid_i` pushes `{data, last}`. `last` = 1 for the sample read from address SAMPLES_PER_BUF-1.
  - A `rd_data_valid_i` with inflight = 0 is ignored.
- FIFO pop on `out_valid_o && out_ready_i`.
  - `out_valid_o` = FIFO not empty.
  - `out_data_o` / `out_last_o` come from the FIFO head.
  - `out_buf_id_o` holds the latched ID until the `last` beat is popped.
- Overrun: `buf_ready_pulse_i` while busy_o = 1 asserts `overrun_pulse_o` next cycle and increments `overrun_count_o` (saturates at 0xFFFF).
  - It also sets `pending` and latches the new ID as the pending ID.
  - A further pulse while `pending` is already set counts again and overwrites the pending ID. Only one frame is queued.
  - The current frame always completes; its data integrity is not guaranteed.
- Simultaneous events:
  - A pulse in the same cycle as the DRAIN exit is treated as pending (counted as an overrun) and is started immediately.
  - Pop and push in the same cycle leave `fifo_count` unchanged.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty; inflight 0; `pending` 0; counter 0.
- Reset asserted mid-frame aborts immediately. No `last` is emitted. The RAM side sees `rd_en_o` = 0 from reset assertion.
- Pulse in cycle 0 → `rd_en_o`/`rd_addr_o`=0 in cycle 1 → `rd_data_valid_i` in cycle 2 → `out_valid_o` in cycle 3.
- With `out_ready_i` held at 1: one sample per cycle, frame beats in cycles 3..SAMPLES_PER_BUF+2, `out_last_o` in cycle SAMPLES_PER_BUF+2, `busy_o` low from cycle SAMPLES_PER_BUF+3.
- Stream rules:
  - Data is stable while valid && !ready.
  - `out_valid_o` never depends combinationally on `out_ready_i`.
- Backpressure: after `out_ready_i` falls, at most FIFO_DEPTH further reads complete, then `rd_en_o` stays 0 until a pop.

## Test plan
- Single frame, ready=1, RAM model holding 0x1000+addr, ID=1 → 256 beats 0x1000..0x10FF in order. `out_last_o` only on 0x10FF. `out_buf_id_o`=1. First valid 3 cycles after the pulse.
- Random `out_ready_i` (50 %) → same 256 values with no loss or duplication. `fifo_count` never exceeds 4. `rd_en_o` is never high when count+inflight = 4.
- `out_ready_i`=0 for 20 cycles at beat 10 → exactly 4 samples buffered. `rd_en_o` low until the first pop. Stream resumes with value 0x100A.
- Second pulse (ID=0) at beat 100 → `overrun_pulse_o` for one cycle, count=1. The first frame completes, then a second 256-beat frame follows with ID=0 and no IDLE cycle in between.
- Three pulses mid-frame → count=3, only one extra frame, carrying the ID of the last pulse.
- `rst_ni` low at beat 50 → all outputs 0 immediately. After release, state IDLE and no output until the next pulse.
